inst_fetch_responder: RTL
=========================

// Module: inst_fetch_responder
// PURPOSE
//   Memory-side responder for the CPU instruction-fetch port (rom_ce/rom_addr -> rom_data).
//   Serves 32-bit instruction words from a byte-wide synchronous instruction memory.
//   Issues four byte reads, assembles them little-endian, and holds the last word in a one-entry buffer.
//   Sits between the CPU top's fetch port and the instruction RAM; rom_ready_o is the fetch stall source.
// PARAMETERS
//   ADDR_W   17  byte-address width presented to the instruction memory
//   MEM_LAT  1   cycles from mem_a_o valid to mem_din_i valid; legal range 1..3
// PORTS
//   clk          in   1       single clock; all state on rising edge
//   rst          in   1       reset, asynchronous, active-low
//   rom_ce_i     in   1       fetch request enable from CPU
//   rom_addr_i   in   32      fetch byte address; bits [1:0] ignored (word-aligned)
//   rom_data_o   out  32      assembled instruction word
//   rom_ready_o  out  1       rom_data_o valid for current rom_addr_i
//   inv_i        in   1       invalidate hold buffer (program load / fence.i)
//   mem_a_o      out  ADDR_W  byte address to instruction memory
//   mem_din_i    in   8       byte returned by memory, MEM_LAT cycles after mem_a_o
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE; hold_valid=0; hold_tag=0; rom_data_o=0; mem_a_o=0; return pipe cleared.
//   Word tag = rom_addr_i[ADDR_W-1:2]. Address bits above ADDR_W are ignored.
//   hit = rom_ce_i & hold_valid & (hold_tag==tag) & ~inv_i.
//   rom_ready_o = hit, combinational; rom_data_o = hold word (registered). A hit costs 0 cycles.
//   FSM IDLE:
//     On rom_ce_i & ~hit: latch req_tag; byte counter k=0; next state FETCH. No memory read issued this cycle.
//   FSM FETCH:
//     Issue cycles k=0..3: mem_a_o={req_tag,k[1:0]}; push {valid,k} into a MEM_LAT-deep return pipe.
//     A pipe entry leaving the pipe writes mem_din_i into byte lane k of the assembly register.
//     After lane 3 is written: hold_word<=assembly, hold_tag<=req_tag, hold_valid<=1; next state IDLE.
//     Miss latency: request seen in cycle t -> rom_ready_o=1 in cycle t+5+MEM_LAT, if the address is held.
//   Abort: in FETCH, (rom_ce_i==0) or (tag!=req_tag) ->
//     return pipe valids cleared; hold buffer untouched; next state IDLE.
//     Restart is evaluated from IDLE on the following cycle.
//   inv_i: clears hold_valid at the next edge; forces rom_ready_o=0 in the same cycle.
//     inv_i during FETCH acts as an abort. inv_i takes priority over a completing fill (word discarded).
//   mem_a_o is 0 in IDLE. Byte lanes: lane0=[7:0] at address+0 ... lane3=[31:24] at address+3.
//   rom_data_o never changes while rom_ready_o=1, except when a new fill completes.
//   No state depends on rom_data_o being consumed.
// STRUCTURE
//   Shared header (defines.v):
//     `InstAddrBus/`InstBus widths; `ByteWidth 8; FSM encodings `FetchIdle/`FetchBusy.
//   Sub-module fetch_ret_pipe:
//     MEM_LAT-deep shift register of {valid, lane[1:0]} with synchronous flush.
//     Everything else is flat in inst_fetch_responder.
// TESTING
//   Reset then rom_ce_i=1, addr=0x0000_0000, mem bytes 13,00,00,00 (MEM_LAT=1)
//     -> rom_ready_o rises in cycle 6, rom_data_o=0x0000_0013.
//   Same addr held 3 more cycles; then addr=0x0000_0002
//     -> rom_ready_o stays 1, mem_a_o stays 0, no new reads (same word, low bits ignored).
//   Fill at 0x10 in flight; addr switches to 0x20 after lane 1 issued
//     -> abort; fill at 0x20 completes; 0x10 never marked valid; bytes for 0x10 never written to hold.
//   rom_ce_i dropped mid-fill, then re-raised with the same addr
//     -> full 4-byte refetch from lane 0; final word correct.
//   inv_i pulsed while hitting 0x4
//     -> rom_ready_o=0 that cycle; next cycle a miss and refetch; data 0xDEADBEEF from bytes EF,BE,AD,DE.
//   Sweep MEM_LAT=1,2,3 with back-to-back sequential addresses 0x0,0x4,0x8
//     -> miss latency 6,7,8 cycles; async rst asserted mid-fill -> all outputs 0 immediately.

Source files
------------

// File: rtl/inst_fetch_responder_pkg.sv
// inst_fetch_responder_pkg: shared widths, fetch FSM states and return-pipe entry type
package inst_fetch_responder_pkg;
  localparam int INST_W = 32;
  localparam int BYTE_W = 8;
  typedef enum logic {FETCH_IDLE, FETCH_BUSY} fetch_state_e;
  typedef struct packed {
    logic       valid;
    logic [1:0] lane;
  } ret_ent_t;
endpackage

// File: rtl/fetch_ret_pipe.sv
// fetch_ret_pipe: DEPTH-deep shift register tracking which byte lane each outstanding read returns to
module fetch_ret_pipe
  import inst_fetch_responder_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  ret_ent_t push,
  output ret_ent_t pop
);
  ret_ent_t stage [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end
  assign pop = stage[DEPTH-1];
endmodule

// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: serves 32-bit fetch words from a byte-wide synchronous memory via a one-word hold buffer
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
#(
  parameter int ADDR_W  = 17,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rom_ce_i,
  input  logic [INST_W-1:0] rom_addr_i,
  output logic [INST_W-1:0] rom_data_o,
  output logic              rom_ready_o,
  input  logic              inv_i,
  output logic [ADDR_W-1:0] mem_a_o,
  input  logic [BYTE_W-1:0] mem_din_i
);
  localparam int TAG_W = ADDR_W - 2;
  fetch_state_e      state, state_nx;
  logic [TAG_W-1:0]  tag, req_tag, hold_tag;
  logic              hold_valid, abort, issue, done, unused_addr_bits;
  logic [2:0]        k;
  logic [INST_W-1:0] asm_word;
  ret_ent_t          push, pop;
  assign tag              = rom_addr_i[ADDR_W-1:2];
  assign unused_addr_bits = ^{rom_addr_i[INST_W-1:ADDR_W], rom_addr_i[1:0]};
  assign rom_ready_o      = rom_ce_i & hold_valid & (hold_tag == tag) & ~inv_i;
  // any change of request while filling drops the fill; the restart happens from IDLE
  assign abort   = (state == FETCH_BUSY) & (~rom_ce_i | (tag != req_tag) | inv_i);
  assign issue   = (state == FETCH_BUSY) & ~k[2] & ~abort;
  assign done    = pop.valid & (pop.lane == 2'd3) & ~abort;
  assign mem_a_o = (state == FETCH_BUSY && !k[2]) ? {req_tag, k[1:0]} : '0;
  assign push    = '{valid: issue, lane: k[1:0]};
  fetch_ret_pipe #(.DEPTH(MEM_LAT)) u_ret_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (push),
    .pop   (pop)
  );
  always_comb begin
    state_nx = (state == FETCH_IDLE) ? ((rom_ce_i & ~rom_ready_o) ? FETCH_BUSY : FETCH_IDLE)
                                     : ((abort | done) ? FETCH_IDLE : FETCH_BUSY);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH_IDLE;
    else        state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_tag    <= '0;
      k          <= '0;
      asm_word   <= '0;
      rom_data_o <= '0;
      hold_tag   <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (state == FETCH_IDLE) begin
        req_tag <= tag;
        k       <= '0;
      end
      if (issue) k <= k + 3'd1;
      if (pop.valid && !abort) asm_word[{pop.lane, 3'b000} +: BYTE_W] <= mem_din_i;
      if (done) begin
        rom_data_o <= {mem_din_i, asm_word[23:0]};
        hold_tag   <= req_tag;
      end
      hold_valid <= ~inv_i & (hold_valid | done);
    end
  end
endmodule
